// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
//   Shared definitions for the cache subsystem: the line-transaction state
//   encoding and the default line/beat/address geometry. The dcache/icache
//   datapaths and the cacheline adaptor all pull their sizes from here so a
//   geometry change happens in one place.
//   No ports (package).
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int DEF_LINE_WIDTH = 256;  // cache line width in bits
  localparam int DEF_BEAT_WIDTH = 64;   // memory burst beat width in bits
  localparam int DEF_ADDR_WIDTH = 32;   // byte address width

  localparam int BEATS  = DEF_LINE_WIDTH / DEF_BEAT_WIDTH;  // beats per line
  localparam int OFFSET = $clog2(DEF_LINE_WIDTH / 8);        // byte-offset bits in a line

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } cache_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//   Memory-side responder for the cache line interface. One full-line read or
//   writeback from the cache becomes a burst of LINE_WIDTH/BEAT_WIDTH beats on
//   the physical memory side, and a single-cycle line_resp_o closes the
//   transaction.
//
// Ports
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   line_read_i    cache line-fill request, held until line_resp_o
//   line_write_i   cache writeback request, held until line_resp_o
//   line_addr_i    request byte address (latched in IDLE)
//   line_i         writeback line data (latched in IDLE)
//   line_o         line buffer contents; the fill line when line_resp_o=1
//   line_resp_o    one-cycle completion pulse
//   burst_addr_o   line-aligned burst address
//   burst_read_o   burst read strobe
//   burst_write_o  burst write strobe
//   burst_o        current write beat
//   burst_i        read beat data, valid with burst_resp_i
//   burst_resp_i   one strobe per accepted beat; gaps allowed
// -----------------------------------------------------------------------------
module cacheline_adaptor
  import cache_pkg::*;
#(
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read_i,
  input  logic                  line_write_i,
  input  logic [ADDR_WIDTH-1:0] line_addr_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  line_resp_o,
  output logic [ADDR_WIDTH-1:0] burst_addr_o,
  output logic                  burst_read_o,
  output logic                  burst_write_o,
  output logic [BEAT_WIDTH-1:0] burst_o,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  input  logic                  burst_resp_i
);

  localparam int LINE_BEATS  = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W       = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int LINE_OFFSET = $clog2(LINE_WIDTH / 8);

  // Clears the within-line byte offset so memory always sees a line-aligned
  // address, regardless of which byte the cache happened to miss on.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << LINE_OFFSET) - ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  cache_state_e          state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [LINE_WIDTH-1:0] line_buf_reg, line_buf_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;

  // Line buffer viewed as an array of beats; beat 0 is the least-significant
  // slice of the line.
  logic [BEAT_WIDTH-1:0] beat_w [LINE_BEATS];

  genvar gi;
  generate
    for (gi = 0; gi < LINE_BEATS; gi++) begin : g_beat
      assign beat_w[gi] = line_buf_reg[gi*BEAT_WIDTH +: BEAT_WIDTH];
    end
  endgenerate

  // Asynchronous reset drops the strobes immediately, aborting any burst in
  // flight without a completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      line_buf_reg <= '0;
      addr_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      line_buf_reg <= line_buf_next;
      addr_reg     <= addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    line_buf_next = line_buf_reg;
    addr_next     = addr_reg;
    burst_read_o  = 1'b0;
    burst_write_o = 1'b0;
    burst_o       = '0;
    line_resp_o   = 1'b0;

    case (state_reg)
      IDLE: begin
        // Writeback takes priority so a dirty victim leaves before its
        // replacement is fetched.
        if (line_write_i) begin
          addr_next     = line_addr_i;
          line_buf_next = line_i;
          cnt_next      = '0;
          state_next    = WRITE;
        end else if (line_read_i) begin
          addr_next  = line_addr_i;
          cnt_next   = '0;
          state_next = READ;
        end
      end

      READ: begin
        burst_read_o = 1'b1;
        if (burst_resp_i) begin
          line_buf_next[cnt_reg*BEAT_WIDTH +: BEAT_WIDTH] = burst_i;
          if (cnt_reg == LAST_BEAT) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      WRITE: begin
        burst_write_o = 1'b1;
        burst_o       = beat_w[cnt_reg];
        if (burst_resp_i) begin
          if (cnt_reg == LAST_BEAT) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      DONE: begin
        // Cache requests are still high here; they are deliberately not
        // sampled so the same request cannot restart a transaction.
        line_resp_o = 1'b1;
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign line_o       = line_buf_reg;
  assign burst_addr_o = addr_reg & ALIGN_MASK;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//   Self-checking bench for cacheline_adaptor. A memory model hands out the
//   beats of a reference line in order according to a per-transaction
//   burst_resp_i pattern; the expected fill line is that reference line and
//   the expected write beats are the slices of the written line.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_read_i;
  logic          line_write_i;
  logic [AW-1:0] line_addr_i;
  logic [LW-1:0] line_i;
  logic [LW-1:0] line_o;
  logic          line_resp_o;
  logic [AW-1:0] burst_addr_o;
  logic          burst_read_o;
  logic          burst_write_o;
  logic [BW-1:0] burst_o;
  logic [BW-1:0] burst_i;
  logic          burst_resp_i;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_addr_i  (line_addr_i),
    .line_i       (line_i),
    .line_o       (line_o),
    .line_resp_o  (line_resp_o),
    .burst_addr_o (burst_addr_o),
    .burst_read_o (burst_read_o),
    .burst_write_o(burst_write_o),
    .burst_o      (burst_o),
    .burst_i      (burst_i),
    .burst_resp_i (burst_resp_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int resp_seen = 0;
  int resp_expected = 0;

  always @(negedge clk) begin
    if (line_resp_o) resp_seen++;
  end

  typedef struct {
    bit            wr;
    bit            rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] wline;
    logic [LW-1:0] rline;
    logic [31:0]   pat;      // burst_resp_i per strobe cycle, LSB first
    int            patlen;   // after patlen cycles memory answers every cycle
    logic [AW-1:0] exp_addr;
  } vec_t;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand256();
    logic [LW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the
  // idle cycle after the response, so back-to-back calls exercise the
  // minimum request spacing.
  task automatic run_txn(input string tag, input vec_t v);
    bit is_wr;
    bit resp;
    bit done;
    int beats;
    int pidx;
    is_wr = v.wr;
    beats = 0;
    pidx  = 0;
    done  = 1'b0;
    line_write_i = v.wr;
    line_read_i  = v.rd;
    line_addr_i  = v.addr;
    line_i       = v.wline;
    burst_resp_i = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (beats == 4) begin
        check({tag, " resp_pulse"}, LW'(line_resp_o), LW'(1'b1));
        check({tag, " rd_strobe_done"}, LW'(burst_read_o), LW'(1'b0));
        check({tag, " wr_strobe_done"}, LW'(burst_write_o), LW'(1'b0));
        if (!is_wr) check({tag, " line_o"}, line_o, v.rline);
        // memory noise and request release during DONE must be ignored
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        burst_resp_i = 1'b1;
        burst_i      = {$urandom, $urandom};
        line_addr_i  = $urandom;
        @(negedge clk);
        check({tag, " resp_single"}, LW'(line_resp_o), LW'(1'b0));
        check({tag, " idle_strobes"}, LW'({burst_read_o, burst_write_o}), LW'(2'b00));
        burst_resp_i = 1'b0;
        done = 1'b1;
        resp_expected++;
      end else begin
        check({tag, " resp_early"}, LW'(line_resp_o), LW'(1'b0));
        check({tag, " burst_read_o"}, LW'(burst_read_o), LW'(!is_wr));
        check({tag, " burst_write_o"}, LW'(burst_write_o), LW'(is_wr));
        check({tag, " burst_addr_o"}, LW'(burst_addr_o), LW'(v.exp_addr));
        if (is_wr) check({tag, " burst_o"}, LW'(burst_o), LW'(v.wline[beats*BW +: BW]));
        resp = (pidx < v.patlen) ? v.pat[pidx] : 1'b1;
        pidx++;
        burst_resp_i = resp;
        burst_i      = resp ? v.rline[beats*BW +: BW] : {$urandom, $urandom};
        if (resp) beats++;
        // address and data changes after the request is taken must not leak in
        line_addr_i = $urandom;
        line_i      = rand256();
      end
    end
    if (!done) begin
      check({tag, " timeout"}, LW'(1'b0), LW'(1'b1));
      line_read_i  = 1'b0;
      line_write_i = 1'b0;
      burst_resp_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    // Directed table
    vecs[0] = '{wr:1'b0, rd:1'b1, addr:32'h0000_1234, wline:'0,
                rline:{64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                pat:32'h0, patlen:0, exp_addr:32'h0000_1220};
    vecs[1] = '{wr:1'b1, rd:1'b0, addr:32'h8000_00FF,
                wline:{64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                rline:'0, pat:32'h0, patlen:0, exp_addr:32'h8000_00E0};
    vecs[2] = '{wr:1'b0, rd:1'b1, addr:32'h0000_2008, wline:'0,
                rline:{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                       64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_1234_8765},
                pat:32'h0000_002D, patlen:6, exp_addr:32'h0000_2000};
    vecs[3] = '{wr:1'b1, rd:1'b0, addr:32'h1000_0047,
                wline:{64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                       64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                rline:'0, pat:32'h0000_0005, patlen:4, exp_addr:32'h1000_0040};
    vecs[4] = '{wr:1'b0, rd:1'b1, addr:32'h2000_007C, wline:'0,
                rline:{64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                       64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001},
                pat:32'h0, patlen:0, exp_addr:32'h2000_0060};
    vecs[5] = '{wr:1'b1, rd:1'b1, addr:32'h0000_00A5,
                wline:{64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                       64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001},
                rline:'0, pat:32'h0, patlen:0, exp_addr:32'h0000_00A0};
    vecs[6] = '{wr:1'b0, rd:1'b1, addr:32'hFFFF_FFFF, wline:'0,
                rline:{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
                pat:32'h0000_0000, patlen:3, exp_addr:32'hFFFF_FFE0};

    rst          = 1'b1;
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    line_addr_i  = '0;
    line_i       = '0;
    burst_i      = '0;
    burst_resp_i = 1'b0;

    @(negedge clk);
    check("reset line_resp_o", LW'(line_resp_o), LW'(1'b0));
    check("reset strobes", LW'({burst_read_o, burst_write_o}), LW'(2'b00));
    check("reset burst_addr_o", LW'(burst_addr_o), LW'(32'h0));
    check("reset burst_o", LW'(burst_o), LW'(64'h0));
    check("reset line_o", line_o, '0);
    rst = 1'b0;

    // memory strobes while idle must not start anything
    burst_resp_i = 1'b1;
    burst_i      = {$urandom, $urandom};
    @(negedge clk);
    check("idle ignores burst_resp_i", LW'({burst_read_o, burst_write_o, line_resp_o}), LW'(3'b000));
    burst_resp_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
      $display("vec%0d wr=%0b rd=%0b addr=%h done", i, vecs[i].wr, vecs[i].rd, vecs[i].addr);
    end

    // Reset two beats into a read: everything drops before the next edge
    line_read_i = 1'b1;
    line_addr_i = 32'h4000_0044;
    @(negedge clk);
    check("abort strobe up", LW'(burst_read_o), LW'(1'b1));
    burst_resp_i = 1'b1;
    burst_i      = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    burst_i      = 64'hDEAD_BEEF_0000_0002;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort burst_read_o", LW'(burst_read_o), LW'(1'b0));
    check("abort burst_write_o", LW'(burst_write_o), LW'(1'b0));
    check("abort line_resp_o", LW'(line_resp_o), LW'(1'b0));
    check("abort burst_addr_o", LW'(burst_addr_o), LW'(32'h0));
    check("abort line_o", line_o, '0);
    @(negedge clk);
    rst          = 1'b0;
    line_read_i  = 1'b0;
    burst_resp_i = 1'b0;
    @(negedge clk);
    run_txn("after_abort", vecs[4]);
    $display("after_abort read addr=%h done", vecs[4].addr);

    // Randomized transactions against the line/beat model
    for (int i = 0; i < 20; i++) begin
      rv.wr       = $urandom_range(0, 1);
      rv.rd       = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.addr     = $urandom;
      rv.wline    = rand256();
      rv.rline    = rand256();
      rv.pat      = $urandom;
      rv.patlen   = 8;
      rv.exp_addr = (rv.addr / 32) * 32;
      run_txn($sformatf("rand%0d", i), rv);
      $display("rand%0d wr=%0b rd=%0b addr=%h done", i, rv.wr, rv.rd, rv.addr);
    end

    repeat (2) @(negedge clk);
    check("resp pulse count", LW'(resp_seen), LW'(resp_expected));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
